// File: rtl/afe_spi_attn_ctrl.sv
// Serial loader for the two AFE attenuator/switch chains: shifts one control word
// MSB first on the selected channel(s), then pulses latch-enable, then idles for one gap.
//
// state | meaning
// IDLE  | waiting for a control-register write
// SHIFT | clocking DATA_WIDTH bits out, low half-period then high half-period per bit
// LATCH | LE high on the selected channels for one half-period
// GAP   | all pins low for one half-period before accepting the next word
module afe_spi_attn_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int CLK_DIV    = 10
) (
  input  logic        sysClk,
  input  logic        sysReset,
  input  logic        sysCsrStrobe,
  input  logic [31:0] sysGpioOut,
  output logic [31:0] sysStatus,
  output logic [1:0]  AFE_SPI_CLK,
  output logic [1:0]  AFE_SPI_SDI,
  output logic [1:0]  AFE_SPI_LE
);

  localparam int BCW = $clog2(DATA_WIDTH) + 1;
  localparam logic [7:0]     HP_LOAD  = 8'(CLK_DIV - 1);
  localparam logic [BCW-1:0] BIT_LOAD = BCW'(DATA_WIDTH - 1);
  localparam logic [BCW-1:0] BIT_ONE  = BCW'(1);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, GAP} state_t;

  state_t                state, state_nxt;
  logic [7:0]            hp_cnt, hp_cnt_nxt;
  logic [BCW-1:0]        bit_cnt, bit_cnt_nxt;
  logic                  clk_hi, clk_hi_nxt;
  logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
  logic [1:0]            mask, mask_nxt;
  logic [15:0]           last_word, last_word_nxt;
  logic                  overrun, overrun_nxt;
  logic [1:0]            spi_clk_nxt, spi_sdi_nxt, spi_le_nxt;
  logic                  wr_req, clr_req, hp_tc;
  logic                  unused_gpio_bits;

  assign unused_gpio_bits = ^sysGpioOut[30:18];
  assign wr_req  = sysCsrStrobe & ~sysGpioOut[31];
  assign clr_req = sysCsrStrobe & sysGpioOut[31];
  assign hp_tc   = (hp_cnt == 8'd0);

  always_comb begin
    state_nxt     = state;
    hp_cnt_nxt    = hp_cnt;
    bit_cnt_nxt   = bit_cnt;
    clk_hi_nxt    = clk_hi;
    shreg_nxt     = shreg;
    mask_nxt      = mask;
    last_word_nxt = last_word;
    overrun_nxt   = overrun;

    case (state)
      IDLE: begin
        if (wr_req) begin
          state_nxt     = SHIFT;
          hp_cnt_nxt    = HP_LOAD;
          bit_cnt_nxt   = BIT_LOAD;
          clk_hi_nxt    = 1'b0;
          shreg_nxt     = sysGpioOut[DATA_WIDTH-1:0];
          mask_nxt      = sysGpioOut[17] ? 2'b11 : (sysGpioOut[16] ? 2'b10 : 2'b01);
          last_word_nxt = sysGpioOut[15:0];
        end
      end
      SHIFT: begin
        if (!hp_tc) begin
          hp_cnt_nxt = hp_cnt - 8'd1;
        end else if (!clk_hi) begin
          clk_hi_nxt = 1'b1;
          hp_cnt_nxt = HP_LOAD;
        end else if (bit_cnt == '0) begin
          state_nxt  = LATCH;
          clk_hi_nxt = 1'b0;
          hp_cnt_nxt = HP_LOAD;
        end else begin
          // falling edge is the bit boundary: advance data here only
          bit_cnt_nxt = bit_cnt - BIT_ONE;
          shreg_nxt   = {shreg[DATA_WIDTH-2:0], 1'b0};
          clk_hi_nxt  = 1'b0;
          hp_cnt_nxt  = HP_LOAD;
        end
      end
      LATCH: begin
        if (!hp_tc) begin
          hp_cnt_nxt = hp_cnt - 8'd1;
        end else begin
          state_nxt  = GAP;
          hp_cnt_nxt = HP_LOAD;
        end
      end
      GAP: begin
        if (!hp_tc) hp_cnt_nxt = hp_cnt - 8'd1;
        else        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // a rejected write sets overrun even when a clear arrives alongside it
    if (wr_req && state != IDLE) overrun_nxt = 1'b1;
    else if (clr_req)            overrun_nxt = 1'b0;

    spi_clk_nxt = (state_nxt == SHIFT && clk_hi_nxt) ? mask_nxt : 2'b00;
    spi_sdi_nxt = (state_nxt == SHIFT && shreg_nxt[DATA_WIDTH-1]) ? mask_nxt : 2'b00;
    spi_le_nxt  = (state_nxt == LATCH) ? mask_nxt : 2'b00;
  end

  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      state       <= IDLE;
      hp_cnt      <= 8'd0;
      bit_cnt     <= '0;
      clk_hi      <= 1'b0;
      shreg       <= '0;
      mask        <= 2'b00;
      last_word   <= 16'd0;
      overrun     <= 1'b0;
      AFE_SPI_CLK <= 2'b00;
      AFE_SPI_SDI <= 2'b00;
      AFE_SPI_LE  <= 2'b00;
    end else begin
      state       <= state_nxt;
      hp_cnt      <= hp_cnt_nxt;
      bit_cnt     <= bit_cnt_nxt;
      clk_hi      <= clk_hi_nxt;
      shreg       <= shreg_nxt;
      mask        <= mask_nxt;
      last_word   <= last_word_nxt;
      overrun     <= overrun_nxt;
      AFE_SPI_CLK <= spi_clk_nxt;
      AFE_SPI_SDI <= spi_sdi_nxt;
      AFE_SPI_LE  <= spi_le_nxt;
    end
  end

  assign sysStatus = {overrun, (state != IDLE), 12'd0, mask, last_word};

endmodule

// File: tb/tb_afe_spi_attn_ctrl.sv
// Bench for afe_spi_attn_ctrl: default instance plus a CLK_DIV=2/DATA_WIDTH=8 instance,
// each compared every cycle against a transfer-timeline reference model.
module tb_afe_spi_attn_ctrl;

  localparam int D0 = 10, W0 = 16, D1 = 2, W1 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]        rst, stb;
  logic [1:0][31:0]  gpio, status;
  logic [1:0][1:0]   sclk, sdi, le;

  int errors = 0;
  int checks = 0;

  afe_spi_attn_ctrl #(.DATA_WIDTH(W0), .CLK_DIV(D0)) dut0 (
    .sysClk(clk), .sysReset(rst[0]), .sysCsrStrobe(stb[0]), .sysGpioOut(gpio[0]),
    .sysStatus(status[0]), .AFE_SPI_CLK(sclk[0]), .AFE_SPI_SDI(sdi[0]), .AFE_SPI_LE(le[0]));

  afe_spi_attn_ctrl #(.DATA_WIDTH(W1), .CLK_DIV(D1)) dut1 (
    .sysClk(clk), .sysReset(rst[1]), .sysCsrStrobe(stb[1]), .sysGpioOut(gpio[1]),
    .sysStatus(status[1]), .AFE_SPI_CLK(sclk[1]), .AFE_SPI_SDI(sdi[1]), .AFE_SPI_LE(le[1]));

  function automatic int dv(input int i);
    return (i == 0) ? D0 : D1;
  endfunction
  function automatic int wd(input int i);
    return (i == 0) ? W0 : W1;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got=%h want=%h", nm, $time, act, exp);
    end
  endtask

  // Reference model: a transfer is a timeline indexed by k = cycles since it started.
  logic [1:0]  m_act, m_ovr;
  int          m_k [2];
  logic [31:0] m_word [2];
  logic [1:0]  m_mask [2], m_lm [2];
  logic [15:0] m_lw [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) begin
        m_act[i] = 1'b0; m_ovr[i] = 1'b0; m_k[i] = 0; m_lw[i] = 16'd0; m_lm[i] = 2'b00;
      end else begin
        logic prior, set_o, clr_o;
        prior = m_act[i]; set_o = 1'b0; clr_o = 1'b0;
        if (prior) begin
          m_k[i]++;
          if (m_k[i] == 2 * dv(i) * wd(i) + 2 * dv(i)) m_act[i] = 1'b0;
        end
        if (stb[i]) begin
          if (gpio[i][31]) clr_o = 1'b1;
          else if (prior)  set_o = 1'b1;
          else begin
            m_act[i] = 1'b1; m_k[i] = 0; m_word[i] = gpio[i];
            m_mask[i] = gpio[i][17] ? 2'b11 : (gpio[i][16] ? 2'b10 : 2'b01);
            m_lm[i] = m_mask[i]; m_lw[i] = gpio[i][15:0];
          end
        end
        if (set_o)      m_ovr[i] = 1'b1;
        else if (clr_o) m_ovr[i] = 1'b0;
      end
    end
  end

  function automatic logic [37:0] model_exp(input int i);
    int k, d, w, b;
    logic [1:0] c, s, l;
    d = dv(i); w = wd(i); c = 2'b00; s = 2'b00; l = 2'b00;
    if (m_act[i]) begin
      k = m_k[i];
      if (k < 2 * d * w) begin
        b = k / (2 * d);
        if ((k % (2 * d)) >= d) c = m_mask[i];
        if (m_word[i][w-1-b])   s = m_mask[i];
      end else if (k < 2 * d * w + d) begin
        l = m_mask[i];
      end
    end
    return {c, s, l, m_ovr[i], m_act[i], 12'd0, m_lm[i], m_lw[i]};
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++)
      check(i == 0 ? "cycle_dut0" : "cycle_dut1",
            {sclk[i], sdi[i], le[i], status[i]}, model_exp(i));
  end

  task automatic wr(input int i, input logic [31:0] v);
    @(negedge clk);
    stb[i] = 1'b1; gpio[i] = v;
    @(negedge clk);
    stb[i] = 1'b0;
  endtask

  task automatic measure(input int i, input int c, input logic [31:0] v,
                         output int rises, output int min_sp, output int max_sp,
                         output logic [31:0] bits, output int busy_n, output int le_n,
                         output int other);
    int last;
    logic pc;
    rises = 0; min_sp = 1000; max_sp = 0; bits = 0; busy_n = 0; le_n = 0; other = 0;
    last = -1; pc = 1'b0;
    wr(i, v);
    for (int n = 0; n < 2 * dv(i) * wd(i) + 2 * dv(i) + 10; n++) begin
      if (sclk[i][c] && !pc) begin
        rises++;
        bits = {bits[30:0], sdi[i][c]};
        if (last >= 0) begin
          if (n - last < min_sp) min_sp = n - last;
          if (n - last > max_sp) max_sp = n - last;
        end
        last = n;
      end
      pc = sclk[i][c];
      busy_n += int'(status[i][30]);
      le_n   += int'(le[i][c]);
      other  += int'(sclk[i][1-c] | sdi[i][1-c] | le[i][1-c]);
      @(negedge clk);
    end
  endtask

  task automatic measure_and_check(input string tag, input int i, input int c,
                                   input logic [31:0] v, input int e_rises, input int e_sp,
                                   input logic [31:0] e_bits, input int e_busy, input int e_le);
    int rises, min_sp, max_sp, busy_n, le_n, other;
    logic [31:0] bits;
    measure(i, c, v, rises, min_sp, max_sp, bits, busy_n, le_n, other);
    check({tag, "_rises"}, rises, e_rises);
    check({tag, "_min_spacing"}, min_sp, e_sp);
    check({tag, "_max_spacing"}, max_sp, e_sp);
    check({tag, "_bits"}, bits, e_bits);
    check({tag, "_busy_cycles"}, busy_n, e_busy);
    check({tag, "_le_cycles"}, le_n, e_le);
    check({tag, "_other_chan"}, other, 0);
  endtask

  typedef struct {
    logic [31:0] gpio;
    int          wait_n;
    logic [31:0] exp_status;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int le_seen;
    logic [31:0] v;

    tbl[0] = '{32'h0002_1234, 100, 32'h4003_1234};
    tbl[1] = '{32'h0000_0F0F, 300, 32'h8003_1234};
    tbl[2] = '{32'h8000_0000,   5, 32'h0003_1234};
    tbl[3] = '{32'h0001_5A5A,   5, 32'h4002_5A5A};
    tbl[4] = '{32'h8000_0000,   5, 32'h4002_5A5A};
    tbl[5] = '{32'h0000_0001, 400, 32'h8002_5A5A};
    tbl[6] = '{32'h0003_0000, 400, 32'h8003_0000};
    tbl[7] = '{32'h8003_0000,   3, 32'h0003_0000};

    rst = 2'b11; stb = 2'b00; gpio = '0;
    repeat (2) @(negedge clk);
    stb[0] = 1'b1; gpio[0] = 32'h0000_A5C3;
    @(negedge clk);
    stb[0] = 1'b0;
    check("reset_status0", status[0], 32'h0);
    check("reset_status1", status[1], 32'h0);
    check("reset_pins0", {sclk[0], sdi[0], le[0]}, 6'd0);
    check("reset_pins1", {sclk[1], sdi[1], le[1]}, 6'd0);
    rst = 2'b00;

    measure_and_check("a5c3", 0, 0, 32'h0000_A5C3, 16, 20, 32'h0000_A5C3, 340, 10);

    for (int n = 0; n < 8; n++) begin
      wr(0, tbl[n].gpio);
      repeat (tbl[n].wait_n) @(negedge clk);
      check($sformatf("table_status_%0d", n), status[0], tbl[n].exp_status);
    end

    // reset during bit 5 aborts the transfer with no latch pulse
    wr(0, 32'h0000_A5C3);
    repeat (105) @(negedge clk);
    check("abort_busy_before", status[0][30], 1'b1);
    rst[0] = 1'b1;
    @(negedge clk);
    check("abort_pins", {sclk[0], sdi[0], le[0]}, 6'd0);
    check("abort_status", status[0], 32'h0);
    @(negedge clk);
    rst[0] = 1'b0;
    le_seen = 0;
    repeat (30) begin
      @(negedge clk);
      le_seen += int'(|le[0]);
    end
    check("abort_no_le", le_seen, 0);
    measure_and_check("after_abort", 0, 0, 32'h0000_A5C3, 16, 20, 32'h0000_A5C3, 340, 10);

    measure_and_check("small_ff", 1, 1, 32'h0001_00FF, 8, 4, 32'h0000_00FF, 36, 2);

    for (int n = 0; n < 150; n++) begin
      int i;
      i = int'($urandom_range(0, 1));
      v = $urandom;
      if ($urandom_range(0, 3) != 0) v[31] = 1'b0;
      if ($urandom_range(0, 19) == 0) begin
        @(negedge clk);
        rst[i] = 1'b1;
        @(negedge clk);
        rst[i] = 1'b0;
      end
      wr(i, v);
      repeat ($urandom_range(0, 400)) @(negedge clk);
    end

    repeat (400) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/afe_spi_attn_ctrl.md
AFE_SPI_ATTN_CTRL -- requirements
Module: afe_spi_attn_ctrl

Interface
REQ-001 Parameter: DATA_WIDTH, default 16, number of bits in one attenuator/switch control word.
REQ-002 Parameter: CLK_DIV, default 10, number of sysClk cycles per SPI half-period; legal values are 2..255.
REQ-003 Port: sysClk, input, 1, system clock (SYSCLK_RATE, nominally 100 MHz); all logic is in this single domain.
REQ-004 Port: sysReset, input, 1, reset; synchronous and active-high.
REQ-005 Port: sysCsrStrobe, input, 1, one-cycle write strobe for the control register.
REQ-006 Port: sysGpioOut, input, 32, write data: [15:0] word (MSB first); [16] channel select; [17] broadcast to both channels; [31] clear overrun.
REQ-007 Port: sysStatus, output, 32, status: [31] overrun; [30] busy; [17:16] channels written by the last transfer; [15:0] last word written.
REQ-008 Port: AFE_SPI_CLK, output, 2, per-AFE serial clock.
REQ-009 Port: AFE_SPI_SDI, output, 2, per-AFE serial data.
REQ-010 Port: AFE_SPI_LE, output, 2, per-AFE latch enable, active-high.

Function
REQ-011 The state machine SHALL have exactly the states IDLE, SHIFT, LATCH and GAP.
REQ-012 In IDLE, a strobe with [31]=0 SHALL capture the word, the channel mask and the last-word status; the state SHALL change to SHIFT on the next cycle.
REQ-013 Channel mask: [17]=1 selects 2'b11; otherwise the mask is one-hot on [16].
REQ-014 A strobe with [31]=1 SHALL clear overrun and SHALL NOT start a transfer, in any state.
REQ-015 A strobe with [31]=0 outside IDLE SHALL be ignored and SHALL set overrun (sticky).
REQ-016 If a clear-overrun strobe and a setting event occur in the same cycle, the set SHALL win.
REQ-017 SHIFT: SDI SHALL present bit DATA_WIDTH-1 from the first SHIFT cycle.
REQ-018 SHIFT: CLK SHALL be low for CLK_DIV cycles, then high for CLK_DIV cycles, per bit.
REQ-019 SHIFT: SDI SHALL change only at the falling CLK edge, i.e. at the bit boundary.
REQ-020 After DATA_WIDTH bits, CLK SHALL return low and the state SHALL change to LATCH.
REQ-021 LATCH: LE SHALL be high for CLK_DIV cycles on the selected channels; CLK and SDI SHALL be low.
REQ-022 GAP: all outputs SHALL be low for CLK_DIV cycles; the state SHALL then return to IDLE.
REQ-023 Unselected channels SHALL hold CLK, SDI and LE low for the whole transfer.
REQ-024 Busy SHALL be high in SHIFT, LATCH and GAP, and low in IDLE.
REQ-025 Transfer length SHALL be 2*CLK_DIV*DATA_WIDTH + 2*CLK_DIV cycles (340 cycles at the defaults).
REQ-026 Outputs SHALL be driven from registers with no combinational path from the inputs.
REQ-027 The half-period counter SHALL be 8 bits wide; the bit counter SHALL be clog2(DATA_WIDTH)+1 bits wide.

Reset
REQ-028 While sysReset is high, the state SHALL be IDLE.
REQ-029 While sysReset is high, all AFE_SPI_* outputs, overrun, busy, and sysStatus[17:0] SHALL be 0.
REQ-030 A reset mid-transfer SHALL abort the transfer: outputs go low on the next cycle and no LE pulse is issued.
REQ-031 A strobe during reset SHALL be ignored.

Verification
REQ-032 Write 0x0000_A5C3 with defaults -> on AFE 0: 16 rising edges, 20 cycles apart; SDI bits sampled on rising CLK equal 1010_0101_1100_0011; LE high for 10 cycles after the last fall; busy high for 340 cycles; AFE 1 pins stay 0.
REQ-033 Write 0x0002_1234 -> identical waveforms on both channels; sysStatus[17:16]=2'b11 and sysStatus[15:0]=0x1234.
REQ-034 Second write 100 cycles into a transfer -> the transfer completes unchanged and overrun=1.
REQ-035 A later write of 0x8000_0000 -> overrun=0 and no SPI activity.
REQ-036 Assert sysReset during bit 5 -> next cycle all outputs 0, busy 0, no LE pulse; a following write runs a complete, correct transfer.
REQ-037 CLK_DIV=2, DATA_WIDTH=8, write 0x0001_00FF -> AFE 1 shifts 8 ones with 4-cycle bit periods; busy lasts 36 cycles.
